// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and widths for the instruction fetch front end.
// ISIZE is the instruction address width. DSIZE is the instruction word width.
// fetch_state_e holds the fetch FSM encodings: RUN=0, HOLD=1, REDIR=2.
package fetch_prefetch_queue_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: a DEPTH-entry FIFO of {pc, inst} pairs for the prefetch queue.
// It supports push, pop and clear, and reports its occupancy.
// A push and a pop in the same cycle leave the count unchanged.
// A pop of an empty FIFO does nothing. There is no bypass from push to head.
module fetch_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [ISIZE-1:0] i_push_pc,
    input  logic [DSIZE-1:0] i_push_inst,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [ISIZE-1:0] o_head_pc,
    output logic [DSIZE-1:0] o_head_inst,
    output logic [PTR_W:0]   o_count,
    output logic             o_empty
);

    logic [ISIZE-1:0] r_pc_mem   [DEPTH];
    logic [DSIZE-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop  && (r_count != '0);
    assign w_do_push = i_push && (r_count != (PTR_W+1)'(DEPTH));

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; occupancy gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
            r_inst_mem[r_wr_ptr] <= i_push_inst;
        end
    end

    assign o_head_pc   = r_pc_mem[r_rd_ptr];
    assign o_head_inst = r_inst_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: the instruction fetch front end.
// It owns the fetch PC and issues reads to instruction memory, which has a
// 1-cycle read latency. Returned words are buffered in a prefetch FIFO that
// feeds decode through a valid/ready handshake. A redirect from EXE flushes
// all wrong-path words.
// Optional build macro: FETCH_STATS_EN adds the o_flush_cnt port, which
// counts the words discarded by redirects.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               PTR_W    = 2,
    parameter logic [ISIZE-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_redirect,
    input  logic [ISIZE-1:0] i_redirect_pc,
    output logic             o_imem_req,
    output logic [ISIZE-1:0] o_imem_addr,
    input  logic [DSIZE-1:0] i_imem_rdata,
    output logic             o_inst_valid,
    input  logic             i_inst_ready,
    output logic [DSIZE-1:0] o_inst,
    output logic [ISIZE-1:0] o_inst_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]      o_flush_cnt
`endif
);

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [ISIZE-1:0] r_fetch_pc;
    logic [ISIZE-1:0] r_issue_pc;
    logic             r_inflight;
    logic [PTR_W:0]   w_count;
    logic             w_empty;
    logic [ISIZE-1:0] w_head_pc;
    logic [DSIZE-1:0] w_head_inst;
    logic [PTR_W+1:0] w_occupancy;
    logic             w_credit;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    // Queued words plus the word still in flight from memory.
    // Issue only while this total is below DEPTH, so the FIFO can never overflow.
    assign w_occupancy = {1'b0, w_count} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_credit    = w_occupancy < (PTR_W+2)'(DEPTH);

    // No request is made while reset is held or while a redirect is active.
    // A redirect makes the current fetch PC wrong-path.
    assign w_issue = !rst && (r_state == ST_RUN) && w_credit && !i_redirect;

    // A redirect drops the word arriving this cycle. So does the bubble after it.
    assign w_push = r_inflight && (r_state != ST_REDIR) && !i_redirect;

    // Decode squashes its own copy of the head in a redirect cycle, so no pop happens here.
    assign w_pop  = o_inst_valid && i_inst_ready && !i_redirect;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_pc   (r_issue_pc),
        .i_push_inst (i_imem_rdata),
        .i_pop       (w_pop),
        .i_clear     (i_redirect),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    // Next-state logic: stall when credit runs out, insert one bubble after a redirect.
    // NOTE: w_next_state gets a default before the case, so no path leaves it unassigned and no latch forms.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (!w_credit && !w_pop) w_next_state = ST_HOLD;
            ST_HOLD:  if (w_credit || w_pop)   w_next_state = ST_RUN;
            ST_REDIR: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
        if (i_redirect) w_next_state = ST_REDIR;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next_state;
    end

    // Fetch PC, the in-flight flag, and the PC of the request awaiting its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_issue_pc <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ISIZE'(1);
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] r_flush_cnt;

    // Count every word a redirect throws away: the queued words plus the arriving word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_flush_cnt <= '0;
        else if (i_redirect) r_flush_cnt <= sat_add16(r_flush_cnt, 16'(w_occupancy));
    end

    assign o_flush_cnt = r_flush_cnt;
`endif

    assign o_imem_req   = w_issue;
    assign o_imem_addr  = r_fetch_pc;
    assign o_inst_valid = !w_empty;
    assign o_inst       = o_inst_valid ? w_head_inst : '0;
    assign o_inst_pc    = o_inst_valid ? w_head_pc   : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue.
// The memory model returns mem[a] = 16'h1000 + a, one cycle after each request.
// A queue-based reference model predicts every output each cycle.
// Define FETCH_STATS_EN to also check o_flush_cnt.
module tb_fetch_prefetch_queue;
    import fetch_prefetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
`ifdef FETCH_STATS_EN
    logic [15:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc)
`ifdef FETCH_STATS_EN
        ,
        .o_flush_cnt   (flush_cnt)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Instruction memory with a 1-cycle read latency.
    always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } entry_t;

    entry_t      m_q[$];
    logic        m_pend;
    logic [15:0] m_pend_pc;
    logic [15:0] m_fpc;
    logic        m_bubble;
    int          m_flush;
    logic        m_exp_req;
    logic        m_exp_valid;
    logic        cur_redir;
    logic [15:0] cur_rpc;
    logic        cur_rdy;
    logic [15:0] delivered[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_fpc     = 16'h0000;
        m_bubble  = 1'b0;
        m_flush   = 0;
    endtask

    // Drive one cycle's inputs (caller sits at a negedge), then compare outputs with the model.
    task automatic drive_and_check(input logic redir, input logic [15:0] rpc, input logic rdy);
        entry_t head;
        cur_redir = redir; cur_rpc = rpc; cur_rdy = rdy;
        redirect = redir; redirect_pc = rpc; inst_ready = rdy;
        #1;
        m_exp_valid = (m_q.size() > 0);
        head        = m_exp_valid ? m_q[0] : '0;
        m_exp_req   = !m_bubble && !redir && ((m_q.size() + int'(m_pend)) < DEPTH);
        check("inst_valid", inst_valid, m_exp_valid);
        check("inst_pc", inst_pc, head.pc);
        check("inst", inst, head.word);
        check("imem_req", imem_req, m_exp_req);
        check("imem_addr", imem_addr, m_fpc);
`ifdef FETCH_STATS_EN
        check("flush_cnt", flush_cnt, 16'(m_flush));
`endif
        if (inst_valid && rdy && !redir) delivered.push_back(inst_pc);
    endtask

    // Apply the clock edge to the model and move on to the next negedge.
    task automatic advance();
        if (cur_redir) begin
            m_flush = m_flush + m_q.size() + int'(m_pend);
            if (m_flush > 65535) m_flush = 65535;
            m_q.delete();
            m_pend   = 1'b0;
            m_fpc    = cur_rpc;
            m_bubble = 1'b1;
        end else begin
            if (m_exp_valid && cur_rdy) void'(m_q.pop_front());
            if (m_pend) m_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
            m_pend    = m_exp_req;
            m_pend_pc = m_fpc;
            if (m_exp_req) m_fpc = m_fpc + 16'd1;
            m_bubble  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic redir, input logic [15:0] rpc, input logic rdy);
        drive_and_check(redir, rpc, rdy);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 16'h0);
        check("rst_inst_pc", inst_pc, 16'h0);
        check("rst_imem_req", imem_req, 1'b0);
`ifdef FETCH_STATS_EN
        check("rst_flush_cnt", flush_cnt, 16'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_req;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t        t1[6];
    logic [15:0] exp_seq[4];
    int          r;

    initial begin
        // T1: first word is visible two edges after the first request, then one word per cycle.
        t1[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        t1[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        t1[2] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002};
        t1[3] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003};
        t1[4] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004};
        t1[5] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005};
        imem_rdata = '0;
        rst = 1'b1;

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_and_check(1'b0, 16'h0, t1[i].ready);
            check($sformatf("t1_valid[%0d]", i), inst_valid, t1[i].exp_valid);
            check($sformatf("t1_pc[%0d]", i), inst_pc, t1[i].exp_pc);
            check($sformatf("t1_inst[%0d]", i), inst,
                  t1[i].exp_valid ? 16'h1000 + t1[i].exp_pc : 16'h0);
            check($sformatf("t1_req[%0d]", i), imem_req, t1[i].exp_req);
            check($sformatf("t1_addr[%0d]", i), imem_addr, t1[i].exp_addr);
            advance();
        end

        // T2: decode stalls and the queue fills; then a gapless restart.
        do_reset();
        repeat (10) step(1'b0, 16'h0, 1'b0);
        drive_and_check(1'b0, 16'h0, 1'b0);
        check("t2_held_valid", inst_valid, 1'b1);
        check("t2_held_pc", inst_pc, 16'h0000);
        check("t2_hold_req", imem_req, 1'b0);
        advance();
        delivered.delete();
        repeat (10) step(1'b0, 16'h0, 1'b1);
        check("t2_delivered_cnt", (delivered.size() >= 8), 1'b1);
        if (delivered.size() >= 8)
            for (int i = 0; i < 8; i++) check($sformatf("t2_seq[%0d]", i), delivered[i], 16'(i));

        // T3: redirect with 3 queued words plus one in flight.
        do_reset();
        repeat (4) step(1'b0, 16'h0, 1'b0);
        drive_and_check(1'b1, 16'h0040, 1'b0);
        check("t3_pre_valid", inst_valid, 1'b1);
        advance();
        drive_and_check(1'b0, 16'h0, 1'b0);
        check("t3_bubble_valid", inst_valid, 1'b0);
        check("t3_bubble_req", imem_req, 1'b0);
        advance();
        drive_and_check(1'b0, 16'h0, 1'b0);
        check("t3_new_req", imem_req, 1'b1);
        check("t3_new_addr", imem_addr, 16'h0040);
        advance();
        step(1'b0, 16'h0, 1'b0);
        drive_and_check(1'b0, 16'h0, 1'b1);
        check("t3_first_valid", inst_valid, 1'b1);
        check("t3_first_pc", inst_pc, 16'h0040);
`ifdef FETCH_STATS_EN
        check("t3_flush_cnt", flush_cnt, 16'd4);
`endif
        advance();

        // T4: the PC wraps from 16'hFFFF to 16'h0000.
        delivered.delete();
        step(1'b1, 16'hFFFE, 1'b1);
        repeat (8) step(1'b0, 16'h0, 1'b1);
        exp_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        check("t4_delivered_cnt", (delivered.size() >= 4), 1'b1);
        if (delivered.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("t4_seq[%0d]", i), delivered[i], exp_seq[i]);

        // T6: a redirect coincides with a handshake, so the pop is ignored and the old path is dropped.
        delivered.delete();
        drive_and_check(1'b1, 16'h0080, 1'b1);
        check("t6_valid_at_redirect", inst_valid, 1'b1);
        advance();
        repeat (8) step(1'b0, 16'h0, 1'b1);
        check("t6_delivered_cnt", (delivered.size() >= 3), 1'b1);
        for (int i = 0; i < delivered.size(); i++)
            check($sformatf("t6_seq[%0d]", i), delivered[i], 16'h0080 + 16'(i));

        // T5: an asynchronous reset between edges kills inst_valid at once.
        drive_and_check(1'b0, 16'h0, 1'b0);
        check("t5_pre_valid", inst_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", inst_valid, 1'b0);
        check("t5_async_req", imem_req, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        delivered.delete();
        repeat (6) step(1'b0, 16'h0, 1'b1);
        check("t5_delivered_cnt", (delivered.size() >= 3), 1'b1);
        if (delivered.size() >= 3)
            for (int i = 0; i < 3; i++) check($sformatf("t5_seq[%0d]", i), delivered[i], 16'(i));

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            step(r < 6,
                 ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 70);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
